fb_row_writer: RTL and testbench



---
 rtl/fb_row_writer_pkg.sv | 11 +
 rtl/fb_row_writer_line_ram.sv | 38 +++
 rtl/fb_row_writer.sv | 131 +++++++++++++
 tb/tb_fb_row_writer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_row_writer_pkg.sv
// Shared type for the fb_row_writer row-copy state machine.
// Widths are left to module parameters; only the state encoding lives here.
package fb_row_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COPY  = 2'd1,
        ST_FLUSH = 2'd2
    } copy_state_e;

endpackage

// File: rtl/fb_row_writer_line_ram.sv
// Double-buffered line buffer: simple dual-port RAM with a registered read port.
// Storage is not reset; only the read register is cleared so mem_data starts at zero.
module fb_line_ram #(
    parameter int LOG_N_COLS = 6,
    parameter int DW         = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_we,
    input  logic [LOG_N_COLS:0]   i_waddr,
    input  logic [DW-1:0]         i_wdata,
    input  logic                  i_re,
    input  logic [LOG_N_COLS:0]   i_raddr,
    output logic [DW-1:0]         o_rdata
);

    localparam int DEPTH = 2 ** (LOG_N_COLS + 1);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/fb_row_writer.sv
// Row receiver: pixel writes into a double-buffered line, row copies into the back
// frame of a double-buffered frame memory, and front/back flips aligned to scan-out.
module fb_row_writer
    import fb_row_writer_pkg::*;
#(
    parameter int N_ROWS     = 64,
    parameter int N_COLS     = 64,
    parameter int LOG_N_ROWS = $clog2(N_ROWS),
    parameter int LOG_N_COLS = $clog2(N_COLS),
    parameter int AW         = 1 + LOG_N_ROWS + LOG_N_COLS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [LOG_N_ROWS-1:0] fbw_row_addr,
    input  logic                  fbw_row_store,
    output logic                  fbw_row_rdy,
    input  logic                  fbw_row_swap,
    input  logic [23:0]           fbw_data,
    input  logic [LOG_N_COLS-1:0] fbw_col_addr,
    input  logic                  fbw_wren,
    input  logic                  frame_swap,
    output logic                  frame_rdy,
    output logic [AW-1:0]         mem_addr,
    output logic [23:0]           mem_data,
    output logic                  mem_we,
    output logic                  disp_frame,
    input  logic                  disp_frame_done
);

    localparam logic [LOG_N_COLS:0] COL_END = (LOG_N_COLS + 1)'(N_COLS);

    copy_state_e           r_state;
    logic                  r_wsel;
    logic                  r_rsel;
    logic [LOG_N_ROWS-1:0] r_row;
    logic [LOG_N_COLS:0]   r_rcol;
    logic                  r_mem_we;
    logic [AW-1:0]         r_mem_addr;
    logic                  r_pending;
    logic                  r_disp_frame;

    logic                  w_idle;
    logic                  w_copy;
    logic                  w_wsel_next;
    logic                  w_store_acc;
    logic [LOG_N_COLS:0]   w_rcol_next;
    logic [23:0]           w_ram_q;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_copy      = (r_state == ST_COPY);
    assign w_wsel_next = r_wsel ^ (fbw_row_swap & w_idle);
    assign fbw_row_rdy = w_idle & ~r_pending;
    assign w_store_acc = fbw_row_store & fbw_row_rdy;
    assign w_rcol_next = r_rcol + 1'b1;

    // The RAM read register doubles as the mem_data register, so the address and
    // strobe are registered on the same edge that issues the read.
    fb_line_ram #(
        .LOG_N_COLS (LOG_N_COLS),
        .DW         (24)
    ) u_line_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (fbw_wren),
        .i_waddr ({r_wsel, fbw_col_addr}),
        .i_wdata (fbw_data),
        .i_re    (w_copy),
        .i_raddr ({r_rsel, r_rcol[LOG_N_COLS-1:0]}),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_wsel     <= 1'b0;
            r_rsel     <= 1'b0;
            r_row      <= '0;
            r_rcol     <= '0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            r_wsel   <= w_wsel_next;
            r_mem_we <= w_copy;
            if (w_copy) begin
                r_mem_addr <= {~r_disp_frame, r_row, r_rcol[LOG_N_COLS-1:0]};
            end
            case (r_state)
                ST_IDLE: begin
                    // A same-cycle swap is applied first, so the line just filled is copied.
                    if (w_store_acc) begin
                        r_row   <= fbw_row_addr;
                        r_rsel  <= ~w_wsel_next;
                        r_rcol  <= '0;
                        r_state <= ST_COPY;
                    end
                end
                ST_COPY: begin
                    r_rcol <= w_rcol_next;
                    if (w_rcol_next == COL_END) begin
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending    <= 1'b0;
            r_disp_frame <= 1'b0;
        end else if (frame_swap && !r_pending) begin
            r_pending <= 1'b1;
        end else if (r_pending && w_idle && disp_frame_done) begin
            r_pending    <= 1'b0;
            r_disp_frame <= ~r_disp_frame;
        end
    end

    assign frame_rdy  = ~r_pending;
    assign disp_frame = r_disp_frame;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_data   = w_ram_q;

endmodule

// File: tb/tb_fb_row_writer.sv
// Directed bench for fb_row_writer: a line-buffer model feeds a scoreboard of
// expected frame-memory writes, checked as mem_we pulses appear.
module tb_fb_row_writer;

    localparam int NR = 64;
    localparam int NC = 64;
    localparam int LR = 6;
    localparam int LC = 6;
    localparam int AW = 1 + LR + LC;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [23:0]   data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [LR-1:0] fbw_row_addr = '0;
    logic          fbw_row_store = 1'b0;
    logic          fbw_row_rdy;
    logic          fbw_row_swap = 1'b0;
    logic [23:0]   fbw_data = '0;
    logic [LC-1:0] fbw_col_addr = '0;
    logic          fbw_wren = 1'b0;
    logic          frame_swap = 1'b0;
    logic          frame_rdy;
    logic [AW-1:0] mem_addr;
    logic [23:0]   mem_data;
    logic          mem_we;
    logic          disp_frame;
    logic          disp_frame_done = 1'b0;

    wr_t         sb[$];
    wr_t         e_mon;
    logic [23:0] line_m [2][NC];
    logic        wsel_m = 1'b0;
    logic        disp_m = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;

    always #5 clk = ~clk;

    fb_row_writer #(
        .N_ROWS (NR),
        .N_COLS (NC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fbw_row_addr    (fbw_row_addr),
        .fbw_row_store   (fbw_row_store),
        .fbw_row_rdy     (fbw_row_rdy),
        .fbw_row_swap    (fbw_row_swap),
        .fbw_data        (fbw_data),
        .fbw_col_addr    (fbw_col_addr),
        .fbw_wren        (fbw_wren),
        .frame_swap      (frame_swap),
        .frame_rdy       (frame_rdy),
        .mem_addr        (mem_addr),
        .mem_data        (mem_data),
        .mem_we          (mem_we),
        .disp_frame      (disp_frame),
        .disp_frame_done (disp_frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int c, input logic [23:0] d);
        fbw_col_addr = LC'(c);
        fbw_data     = d;
        fbw_wren     = 1'b1;
        tick();
        fbw_wren     = 1'b0;
        line_m[wsel_m][c] = d;
    endtask

    // push=1 only when the store is known to be accepted
    task automatic store(input int row, input logic swap, input logic push);
        fbw_row_addr  = LR'(row);
        fbw_row_store = 1'b1;
        fbw_row_swap  = swap;
        tick();
        fbw_row_store = 1'b0;
        fbw_row_swap  = 1'b0;
        if (push) begin
            if (swap) wsel_m = ~wsel_m;
            for (int c = 0; c < NC; c++) begin
                sb.push_back('{addr: {~disp_m, LR'(row), LC'(c)}, data: line_m[~wsel_m][c]});
            end
        end
    endtask

    task automatic pulse_done();
        disp_frame_done = 1'b1;
        tick();
        disp_frame_done = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            wr_cnt++;
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL sb_unexpected_write observed=%0h expected=none", mem_addr);
            end
            if (sb.size() > 0) begin
                e_mon = sb.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e_mon.addr));
                chk("wr_data", 32'(mem_data), 32'(e_mon.data));
            end
        end
    end

    initial begin
        // reset
        repeat (3) tick();
        chk("rst_row_rdy", 32'(fbw_row_rdy), 1);
        chk("rst_frame_rdy", 32'(frame_rdy), 1);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_data", 32'(mem_data), 0);
        chk("rst_disp", 32'(disp_frame), 0);
        rst_n = 1'b1;
        tick();

        // single row: swap+store row 5 in the same cycle
        for (int c = 0; c < NC; c++) pix(c, 24'(c));
        wr_cnt = 0;
        store(5, 1'b1, 1'b1);
        chk("single_rdy_t1", 32'(fbw_row_rdy), 0);
        chk("single_we_t1", 32'(mem_we), 0);
        tick();
        chk("single_we_t2", 32'(mem_we), 1);
        chk("single_addr_t2", 32'(mem_addr), 32'({1'b1, 6'd5, 6'd0}));
        repeat (NC - 1) tick();
        chk("single_we_last", 32'(mem_we), 1);
        chk("single_rdy_last", 32'(fbw_row_rdy), 0);
        tick();
        chk("single_rdy_t66", 32'(fbw_row_rdy), 1);
        chk("single_we_t66", 32'(mem_we), 0);
        chk("single_count", 32'(wr_cnt), NC);

        // busy drop
        for (int c = 0; c < NC; c++) pix(c, 24'h000100 + 24'(c));
        wr_cnt = 0;
        store(7, 1'b1, 1'b1);
        repeat (9) tick();
        store(9, 1'b0, 1'b0);
        repeat (NC) tick();
        chk("busy_count", 32'(wr_cnt), NC);
        chk("busy_sb_empty", 32'(sb.size()), 0);

        // swap during copy; pixel writes during copy go to the write half
        for (int c = 0; c < NC; c++) pix(c, 24'h000200 + 24'(c));
        store(3, 1'b1, 1'b1);
        for (int i = 0; i < NC; i++) begin
            fbw_col_addr = LC'(i);
            fbw_data     = 24'hAA0000 + 24'(i);
            fbw_wren     = 1'b1;
            fbw_row_swap = (i == 4);
            tick();
            line_m[wsel_m][i] = 24'hAA0000 + 24'(i);
        end
        fbw_wren = 1'b0;
        fbw_row_swap = 1'b0;
        repeat (2) tick();
        store(4, 1'b0, 1'b1);
        repeat (NC + 2) tick();
        store(6, 1'b1, 1'b1);
        repeat (NC + 2) tick();
        chk("swapcopy_sb_empty", 32'(sb.size()), 0);

        // frame flip
        frame_swap = 1'b1;
        tick();
        frame_swap = 1'b0;
        chk("flip_frame_rdy_pend", 32'(frame_rdy), 0);
        chk("flip_row_rdy_pend", 32'(fbw_row_rdy), 0);
        repeat (19) tick();
        chk("flip_frame_rdy_wait", 32'(frame_rdy), 0);
        chk("flip_disp_wait", 32'(disp_frame), 0);
        pulse_done();
        disp_m = 1'b1;
        chk("flip_disp", 32'(disp_frame), 1);
        chk("flip_frame_rdy", 32'(frame_rdy), 1);
        chk("flip_row_rdy", 32'(fbw_row_rdy), 1);
        store(2, 1'b0, 1'b1);
        tick();
        chk("flip_back_bit", 32'(mem_addr[AW-1]), 0);
        repeat (NC + 1) tick();

        // frame_swap and done in the same cycle
        frame_swap = 1'b1;
        disp_frame_done = 1'b1;
        tick();
        frame_swap = 1'b0;
        disp_frame_done = 1'b0;
        chk("sim_disp_hold", 32'(disp_frame), 1);
        chk("sim_frame_rdy", 32'(frame_rdy), 0);
        repeat (3) tick();
        pulse_done();
        disp_m = 1'b0;
        chk("sim_disp_flip", 32'(disp_frame), 0);
        chk("sim_frame_rdy_after", 32'(frame_rdy), 1);

        // done pulse during copy is ignored
        store(1, 1'b0, 1'b1);
        frame_swap = 1'b1;
        tick();
        frame_swap = 1'b0;
        repeat (5) tick();
        pulse_done();
        chk("copydone_disp", 32'(disp_frame), 0);
        chk("copydone_frame_rdy", 32'(frame_rdy), 0);
        repeat (NC + 2) tick();
        chk("copydone_we_idle", 32'(mem_we), 0);
        chk("copydone_disp_idle", 32'(disp_frame), 0);
        pulse_done();
        disp_m = 1'b1;
        chk("copydone_disp_flip", 32'(disp_frame), 1);
        chk("copydone_row_rdy", 32'(fbw_row_rdy), 1);
        chk("copydone_sb_empty", 32'(sb.size()), 0);

        // reset mid-copy
        store(8, 1'b0, 1'b1);
        repeat (29) tick();
        chk("rstmid_we_before", 32'(mem_we), 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_we", 32'(mem_we), 0);
        chk("rstmid_row_rdy", 32'(fbw_row_rdy), 1);
        chk("rstmid_frame_rdy", 32'(frame_rdy), 1);
        chk("rstmid_disp", 32'(disp_frame), 0);
        chk("rstmid_addr", 32'(mem_addr), 0);
        chk("rstmid_data", 32'(mem_data), 0);
        sb.delete();
        wsel_m = 1'b0;
        disp_m = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        wr_cnt = 0;
        store(10, 1'b0, 1'b1);
        repeat (NC + 2) tick();
        chk("rstmid_burst_count", 32'(wr_cnt), NC);
        chk("rstmid_sb_empty", 32'(sb.size()), 0);
        chk("rstmid_row_rdy_end", 32'(fbw_row_rdy), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
